// File: rtl/trap_filter_cfg_if.sv
// Sample, configuration and status bundle for the trapezoidal shaper.
// master drives samples and config; slave is the filter.
interface trap_filter_cfg_if #(
    parameter int ADC_W = 14,
    parameter int OUT_W = 16,
    parameter int KL_W  = 7,
    parameter int M_W   = 10
);
    logic                    in_valid;
    logic signed [ADC_W-1:0] in_data;
    logic                    cfg_load;
    logic [KL_W-1:0]         cfg_k;
    logic [KL_W-1:0]         cfg_l;
    logic [M_W-1:0]          cfg_m;
    logic [4:0]              cfg_shift;
    logic                    out_valid;
    logic signed [OUT_W-1:0] out_data;
    logic                    busy;
    logic                    cfg_err;
    logic                    ovf;

    modport master (
        output in_valid, in_data,
        output cfg_load, cfg_k, cfg_l, cfg_m, cfg_shift,
        input  out_valid, out_data, busy, cfg_err, ovf
    );

    modport slave (
        input  in_valid, in_data,
        input  cfg_load, cfg_k, cfg_l, cfg_m, cfg_shift,
        output out_valid, out_data, busy, cfg_err, ovf
    );
endinterface

// File: rtl/trap_filter_cfg.sv
// Runtime-configurable trapezoidal shaper: delay-line differences, two
// accumulators with pole-zero term, saturating output, warm-up gating.
module trap_filter_cfg #(
    parameter int ADC_W     = 14,
    parameter int OUT_W     = 16,
    parameter int ACC_W     = 32,
    parameter int DEPTH     = 64,
    parameter int KL_W      = 7,
    parameter int M_W       = 10,
    parameter int DEF_K     = 4,
    parameter int DEF_L     = 6,
    parameter int DEF_M     = 0,
    parameter int DEF_SHIFT = 0
) (
    input  logic clk,
    input  logic reset,
    trap_filter_cfg_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic signed [ACC_W-1:0] OMAX =
        ACC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] OMIN = ~OMAX;

    typedef enum logic {WARMUP, RUN} state_t;

    state_t                  state;
    logic [KL_W-1:0]         k, l;
    logic [M_W-1:0]          m;
    logic [4:0]              sh;
    logic [KL_W:0]           cnt;
    logic signed [ADC_W-1:0] dl [DEPTH];
    logic signed [ACC_W-1:0] d1, d2, d, p, md, s;
    logic                    v1, v2, v3, v4;
    logic                    e1, e2, e3, e4;

    logic [KL_W:0]           kl, ksum;
    logic [IDX_W-1:0]        ik, il, ikl;
    logic                    cfg_ok, acc;
    logic signed [ACC_W-1:0] shv;
    logic                    clamp_hi, clamp_lo;
    logic signed [OUT_W-1:0] sat;

    function automatic logic signed [ACC_W-1:0] sx(
        input logic signed [ADC_W-1:0] v);
        return {{(ACC_W-ADC_W){v[ADC_W-1]}}, v};
    endfunction

    always_comb begin
        kl   = {1'b0, k} + {1'b0, l};
        ksum = {1'b0, bus.cfg_k} + {1'b0, bus.cfg_l};
        // history entry j holds x[n-1-j], so tap x[n-T] is entry T-1
        ik   = IDX_W'(k - KL_W'(1));
        il   = IDX_W'(l - KL_W'(1));
        ikl  = IDX_W'(kl - (KL_W+1)'(1));
        cfg_ok = (bus.cfg_k != '0) &&
                 (bus.cfg_l >= bus.cfg_k) &&
                 (ksum <= (KL_W+1)'(DEPTH));
        acc  = bus.in_valid & ~bus.cfg_load;
        shv  = s >>> sh;
        clamp_hi = shv > OMAX;
        clamp_lo = shv < OMIN;
        sat  = shv[OUT_W-1:0];
        if (clamp_hi) sat = OMAX[OUT_W-1:0];
        if (clamp_lo) sat = OMIN[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= WARMUP;
            k             <= KL_W'(DEF_K);
            l             <= KL_W'(DEF_L);
            m             <= M_W'(DEF_M);
            sh            <= 5'(DEF_SHIFT);
            cnt           <= '0;
            for (int i = 0; i < DEPTH; i++) dl[i] <= '0;
            d1            <= '0;
            d2            <= '0;
            d             <= '0;
            p             <= '0;
            md            <= '0;
            s             <= '0;
            {v1, v2, v3, v4} <= '0;
            {e1, e2, e3, e4} <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.busy      <= 1'b1;
            bus.cfg_err   <= 1'b0;
            bus.ovf       <= 1'b0;
        end else begin
            v1 <= acc;
            e1 <= acc & (state == RUN);
            v2 <= v1;
            e2 <= e1;
            v3 <= v2;
            e3 <= e2;
            v4 <= v3;
            e4 <= e3;
            bus.out_valid <= v4 & e4;
            if (acc) begin
                dl[0] <= bus.in_data;
                for (int i = 1; i < DEPTH; i++) dl[i] <= dl[i-1];
                d1 <= sx(bus.in_data) - sx(dl[ik]);
                d2 <= sx(dl[il]) - sx(dl[ikl]);
                if (state == WARMUP) begin
                    if (cnt == kl - (KL_W+1)'(1)) begin
                        state    <= RUN;
                        bus.busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
            if (v1) d <= d1 - d2;
            if (v2) begin
                p  <= p + d;
                md <= d * $signed({{(ACC_W-M_W){1'b0}}, m});
            end
            if (v3) s <= s + p + md;
            if (v4) begin
                bus.out_data <= sat;
                if (clamp_hi | clamp_lo) bus.ovf <= 1'b1;
            end
            // a rejected load leaves the running filter untouched
            if (bus.cfg_load) begin
                if (cfg_ok) begin
                    state         <= WARMUP;
                    k             <= bus.cfg_k;
                    l             <= bus.cfg_l;
                    m             <= bus.cfg_m;
                    sh            <= bus.cfg_shift;
                    cnt           <= '0;
                    for (int i = 0; i < DEPTH; i++) dl[i] <= '0;
                    d1            <= '0;
                    d2            <= '0;
                    d             <= '0;
                    p             <= '0;
                    md            <= '0;
                    s             <= '0;
                    {v1, v2, v3, v4} <= '0;
                    {e1, e2, e3, e4} <= '0;
                    bus.out_valid <= 1'b0;
                    bus.busy      <= 1'b1;
                    bus.cfg_err   <= 1'b0;
                    bus.ovf       <= 1'b0;
                end else begin
                    bus.cfg_err   <= 1'b1;
                end
            end
        end
    end

endmodule
